seg_scan_mux: RTL

Parametrised multiplexed 7-segment display driver, successor to the fixed four-digit LED driver. Drives DIGITS common-anode digits from a double-buffered register bank: a host writes per-digit hex value, decimal point and blank flag into a shadow bank, and the bank becomes visible atomically at the next frame boundary. Adds anode dead-time against ghosting and a frame tick. Sits between board pins and any counter/status logic that wants a display.

---
 rtl/seg_pkg.sv | 42 ++++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg_scan_mux.sv | 107 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for 7-segment display blocks.
//   SEG_OFF     : all segments dark (active-low).
//   digit_t     : one display-bank entry {blank, dp, data}.
//   DIGIT_RESET : bank entry after reset (dark digit showing 0).
//   hex_to_seg  : nibble to active-low {a,b,c,d,e,f,g} pattern.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] data;
  } digit_t;

  localparam digit_t DIGIT_RESET = '{blank: 1'b1, dp: 1'b0, data: 4'h0};

  // Active-low segment pattern, a is the MSB.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment decoder.
//   hex   in  4  nibble to display
//   seg_c out 7  active-low {a,b,c,d,e,f,g}
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  assign seg_c = hex_to_seg(hex);

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed common-anode 7-segment driver with a double-buffered digit bank.
// Host writes land in the shadow bank; a commit copies shadow to live at the
// next frame boundary so the display never shows a half-updated frame.
//   clk, reset           clock, synchronous active-high reset
//   wr_en/wr_idx/wr_data/wr_dp/wr_blank   shadow-bank write port
//   commit               request shadow->live copy at next frame boundary
//   commit_pending  out  copy requested but not yet done
//   an              out  anodes, active-low, an[0] rightmost
//   seg             out  segments {a..g}, active-low
//   dp              out  decimal point, active-low
//   frame_tick      out  one-cycle pulse after each frame boundary
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 16,
  parameter int unsigned DEAD   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DIGITS)-1:0]  wr_idx,
  input  logic [3:0]                 wr_data,
  input  logic                       wr_dp,
  input  logic                       wr_blank,
  input  logic                       commit,
  output logic                       commit_pending,
  output logic [DIGITS-1:0]          an,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic                       frame_tick
);

  localparam int unsigned IDX_W  = $clog2(DIGITS);
  localparam int unsigned SLOT_W = $clog2(DIV);

  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  dig_cnt;
  digit_t            shadow [DIGITS];
  digit_t            live   [DIGITS];

  digit_t     cur_c;
  logic [6:0] seg_dec_c;
  logic       slot_wrap_c;
  logic       boundary_c;
  logic       dark_c;
  logic       wr_ok_c;

  // Current digit state and scan-position decode.
  always_comb begin
    cur_c       = live[dig_cnt];
    slot_wrap_c = (slot_cnt == SLOT_W'(DIV - 1));
    boundary_c  = slot_wrap_c && (dig_cnt == IDX_W'(DIGITS - 1));
    dark_c      = (slot_cnt < SLOT_W'(DEAD)) || cur_c.blank;
    wr_ok_c     = (32'(wr_idx) < DIGITS);
  end

  seg7_hex_decode u_dec (
    .hex   (cur_c.data),
    .seg_c (seg_dec_c)
  );

  // Scan counters, banks, commit handshake and registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt       <= '0;
      dig_cnt        <= '0;
      commit_pending <= 1'b0;
      an             <= '1;
      seg            <= SEG_OFF;
      dp             <= 1'b1;
      frame_tick     <= 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
        shadow[i] <= DIGIT_RESET;
        live[i]   <= DIGIT_RESET;
      end
    end else begin
      if (slot_wrap_c) begin
        slot_cnt <= '0;
        dig_cnt  <= (dig_cnt == IDX_W'(DIGITS - 1)) ? '0 : dig_cnt + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end

      frame_tick <= boundary_c;
      an         <= dark_c ? '1 : ~(DIGITS'(1) << dig_cnt);
      seg        <= dark_c ? SEG_OFF : seg_dec_c;
      dp         <= dark_c ? 1'b1 : ~cur_c.dp;

      // Copy uses pre-write shadow values; a commit landing on the boundary
      // itself sets pending and waits for the following boundary.
      if (boundary_c && commit_pending) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          live[i] <= shadow[i];
        end
        commit_pending <= 1'b0;
      end else if (commit && !commit_pending) begin
        commit_pending <= 1'b1;
      end

      if (wr_en && wr_ok_c) begin
        shadow[wr_idx] <= '{blank: wr_blank, dp: wr_dp, data: wr_data};
      end
    end
  end

endmodule
